// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared wires and constants for the instruction/data memory arbiter.
//   mem_in_type           : request bundle (requester -> memory)
//   mem_out_type          : response bundle (memory -> requester)
//   arbiter_state_type    : IDLE / BUSY_I / BUSY_D
//   pend_type             : one-entry pending slot (valid + full request)
//   mem_arbiter_reg_type  : complete registered state of the arbiter
//   STARVE_MAX_DEFAULT    : default bound on data grants while imem waits
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int CNT_W  = 4;

    localparam int STARVE_MAX_DEFAULT = 4;

    typedef struct packed {
        logic              mem_valid;
        logic              mem_instr;
        logic              mem_fence;
        logic [ADDR_W-1:0] mem_addr;
        logic [DATA_W-1:0] mem_wdata;
        logic [STRB_W-1:0] mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic              mem_ready;
        logic [DATA_W-1:0] mem_rdata;
    } mem_out_type;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arbiter_state_type;

    typedef struct packed {
        logic       valid;
        mem_in_type req;
    } pend_type;

    typedef struct packed {
        arbiter_state_type state;
        pend_type          ipend;
        pend_type          dpend;
        logic [CNT_W-1:0]  starve_cnt;
    } mem_arbiter_reg_type;

    localparam mem_arbiter_reg_type REG_RESET = '{
        state:      IDLE,
        ipend:      '0,
        dpend:      '0,
        starve_cnt: '0
    };

    // Turns a stored/incoming request into the bundle driven to memory:
    // valid forced high, instruction flag forced by the owning port.
    function automatic mem_in_type issue_req(input mem_in_type req, input logic instr);
        mem_in_type o;
        o           = req;
        o.mem_valid = 1'b1;
        o.mem_instr = instr;
        return o;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between an instruction requester and a data
// requester. One transaction is in flight at a time.
//
// Handshake: a requester presents a request by holding mem_valid=1 for one
// cycle (the arbiter captures it if it cannot issue immediately). The arbiter
// issues to memory with mem_in.mem_valid=1 for exactly one cycle; the
// transaction completes on the cycle memory returns mem_ready=1, which is
// forwarded combinationally to the owning requester only.
//
// Ports:
//   rst       in   synchronous, active-low reset
//   clk       in   clock
//   imem_in   in   instruction request
//   imem_out  out  instruction response
//   dmem_in   in   data request
//   dmem_out  out  data response
//   mem_in    out  request to shared memory
//   mem_out   in   response from shared memory
//   dbg_r     out  registered arbiter state (FSM state, pending slots, starve_cnt)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                rst,
    input  logic                clk,
    input  mem_in_type          imem_in,
    output mem_out_type         imem_out,
    input  mem_in_type          dmem_in,
    output mem_out_type         dmem_out,
    output mem_in_type          mem_in,
    input  mem_out_type         mem_out,
    output mem_arbiter_reg_type dbg_r
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    mem_arbiter_reg_type r;
    mem_arbiter_reg_type rin;

    mem_in_type i_req;
    mem_in_type d_req;
    logic       i_has;
    logic       d_has;
    logic       done;
    logic       can_issue;
    logic       grant_i;
    logic       grant_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r <= REG_RESET;
        end else begin
            r <= rin;
        end
    end

    // Next-state: arbitration, pending slots, starvation counter
    always_comb begin
        mem_arbiter_reg_type v;
        v = r;

        // A pending entry is older than the incoming one, so it goes first.
        i_req = r.ipend.valid ? r.ipend.req : imem_in;
        d_req = r.dpend.valid ? r.dpend.req : dmem_in;
        i_has = r.ipend.valid | imem_in.mem_valid;
        d_has = r.dpend.valid | dmem_in.mem_valid;

        done = (r.state != IDLE) & mem_out.mem_ready;
        // The completion cycle is also an issue opportunity (back-to-back).
        can_issue = rst & ((r.state == IDLE) | done);

        grant_i = 1'b0;
        grant_d = 1'b0;
        if (can_issue && i_has && (!d_has || r.starve_cnt == STARVE_LIM)) begin
            grant_i = 1'b1;
        end else if (can_issue && d_has) begin
            grant_d = 1'b1;
        end

        // Pending slots: if the pending entry was issued, a simultaneous
        // incoming request takes its place; otherwise incoming overwrites.
        if (grant_i) begin
            v.ipend.valid = r.ipend.valid & imem_in.mem_valid;
            if (r.ipend.valid) begin
                v.ipend.req = imem_in;
            end
        end else if (imem_in.mem_valid) begin
            v.ipend.valid = 1'b1;
            v.ipend.req   = imem_in;
        end

        if (grant_d) begin
            v.dpend.valid = r.dpend.valid & dmem_in.mem_valid;
            if (r.dpend.valid) begin
                v.dpend.req = dmem_in;
            end
        end else if (dmem_in.mem_valid) begin
            v.dpend.valid = 1'b1;
            v.dpend.req   = dmem_in;
        end

        if (grant_i) begin
            v.starve_cnt = '0;
        end else if (grant_d && i_has && r.starve_cnt != STARVE_LIM) begin
            v.starve_cnt = r.starve_cnt + 1'b1;
        end

        if (grant_i) begin
            v.state = BUSY_I;
        end else if (grant_d) begin
            v.state = BUSY_D;
        end else if (done) begin
            v.state = IDLE;
        end

        rin = v;
    end

    // Outputs: issued request and response routing
    always_comb begin
        mem_in   = '0;
        imem_out = '0;
        dmem_out = '0;
        if (rst) begin
            if (grant_i) begin
                mem_in = issue_req(i_req, 1'b1);
            end else if (grant_d) begin
                mem_in = issue_req(d_req, 1'b0);
            end
            if (r.state == BUSY_I) begin
                imem_out = mem_out;
            end
            if (r.state == BUSY_D) begin
                dmem_out = mem_out;
            end
        end
    end

    assign dbg_r = r;

endmodule
